// File: rtl/i2c_master_pkg.sv
// Shared encodings for the single-byte I2C master: FSM states, quarter-bit
// phase indices and the scl waveform used by every bit slot.
package i2c_master_pkg;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] START    = 4'd1;
  localparam logic [3:0] ADDR     = 4'd2;
  localparam logic [3:0] ADDR_ACK = 4'd3;
  localparam logic [3:0] WDATA    = 4'd4;
  localparam logic [3:0] RDATA    = 4'd5;
  localparam logic [3:0] DATA_ACK = 4'd6;
  localparam logic [3:0] STOP     = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  // scl is high in the middle two phases of a slot; STOP keeps it high from
  // P1 onward so the released sda rises while scl is high.
  function automatic logic scl_level(input logic [3:0] state, input logic [1:0] phase);
    if (state == IDLE || state == DONE) return 1'b1;
    if (state == STOP) return phase != P0;
    return (phase == P1) || (phase == P2);
  endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Host strobe interface plus scl for the I2C master; sda stays a plain inout
// port on the controller so the tri-state net lives at the bus boundary.
interface i2c_master_if;
  logic       newd;
  logic       ack;
  logic       wr;
  logic [7:0] wdata;
  logic [6:0] addr;
  logic       scl;
  logic [7:0] rdata;
  logic       done;

  modport master (input newd, ack, wr, wdata, addr, output scl, rdata, done);
  modport slave  (output newd, ack, wr, wdata, addr, input scl, rdata, done);
endinterface

// File: rtl/i2c_master_phase_gen.sv
// Quarter-bit phase divider: PHASE_CLKS clocks per phase, four phases per bit
// slot, held at P0 whenever run is low so each transaction starts aligned.
module i2c_phase_gen
  import i2c_master_pkg::*;
#(
  parameter int PHASE_CLKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [1:0] phase,
  output logic       phase_end
);

  localparam int CW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_CLKS - 1);

  logic [CW-1:0] cnt;

  assign phase_end = run && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt   <= '0;
      phase <= P0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP, then a
// one-clock done pulse. The slave acknowledge arrives on the ack input.
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int PHASE_CLKS = 1
) (
  input  logic clk,
  input  logic rst,
  i2c_master_if.master bus,
  inout  wire  sda
);

  logic [3:0] state;
  logic [1:0] phase;
  logic       phase_end;
  logic       run;
  logic       slot_end;
  logic       sample_pt;
  logic [2:0] bit_cnt;
  logic [7:0] addr_byte;
  logic [7:0] wdata_q;
  logic [7:0] shift_q;
  logic       wr_q;
  logic       ack_q;
  logic       sda_oe;
  logic       sda_out;

  assign run       = (state != IDLE) && (state != DONE);
  assign slot_end  = phase_end && (phase == P3);
  assign sample_pt = phase_end && (phase == P2);

  i2c_phase_gen #(.PHASE_CLKS(PHASE_CLKS)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .phase     (phase),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath is reset along with the FSM so rdata reads 00
      // after reset and no X ever reaches the bus outputs.
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      addr_byte <= 8'h00;
      wdata_q   <= 8'h00;
      shift_q   <= 8'h00;
      wr_q      <= 1'b0;
      ack_q     <= 1'b0;
      bus.rdata <= 8'h00;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= (state == DONE);
      if (sample_pt) begin
        ack_q <= bus.ack;
        if (state == RDATA) shift_q <= {shift_q[6:0], sda};
      end
      case (state)
        IDLE: if (bus.newd) begin
          addr_byte <= {bus.addr, ~bus.wr};
          wr_q      <= bus.wr;
          wdata_q   <= bus.wdata;
          state     <= START;
        end
        START: if (slot_end) begin
          state   <= ADDR;
          bit_cnt <= 3'd7;
        end
        ADDR: if (slot_end) begin
          if (bit_cnt == 3'd0) state <= ADDR_ACK;
          else bit_cnt <= bit_cnt - 3'd1;
        end
        ADDR_ACK: if (slot_end) begin
          bit_cnt <= 3'd7;
          if (!ack_q)    state <= STOP;
          else if (wr_q) state <= WDATA;
          else           state <= RDATA;
        end
        WDATA: if (slot_end) begin
          if (bit_cnt == 3'd0) state <= DATA_ACK;
          else bit_cnt <= bit_cnt - 3'd1;
        end
        RDATA: if (slot_end) begin
          if (bit_cnt == 3'd0) begin
            state     <= DATA_ACK;
            bus.rdata <= shift_q;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        // ACK and NACK both end in STOP; a write NACK needs no special path.
        DATA_ACK: if (slot_end) state <= STOP;
        STOP:     if (slot_end) state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // NOTE: defaults first so every path assigns both signals and no latch forms.
  always_comb begin
    sda_oe  = 1'b0;
    sda_out = 1'b1;
    case (state)
      START: begin
        sda_oe  = 1'b1;
        sda_out = (phase == P0) || (phase == P1);
      end
      ADDR: begin
        sda_oe  = 1'b1;
        sda_out = addr_byte[bit_cnt];
      end
      WDATA: begin
        sda_oe  = 1'b1;
        sda_out = wdata_q[bit_cnt];
      end
      DATA_ACK: sda_oe = !wr_q;
      STOP: begin
        sda_oe  = (phase == P0) || (phase == P1);
        sda_out = 1'b0;
      end
      default: ;
    endcase
  end

  assign sda     = sda_oe ? sda_out : 1'bz;
  assign bus.scl = scl_level(state, phase);

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: two instances (PHASE_CLKS 1 and 3) on pulled-up sda
// nets, checked cycle by cycle against a slot/phase timeline model.
module tb_i2c_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_master_if bus1 ();
  i2c_master_if bus3 ();

  wire sda1;
  wire sda3;
  pullup (sda1);
  pullup (sda3);

  logic sel;
  logic drv_en;
  logic drv_bit;
  assign sda1 = (drv_en && !sel) ? drv_bit : 1'bz;
  assign sda3 = (drv_en &&  sel) ? drv_bit : 1'bz;

  i2c_master #(.PHASE_CLKS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .sda(sda1));
  i2c_master #(.PHASE_CLKS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .sda(sda3));

  wire       scl_m   = sel ? bus3.scl   : bus1.scl;
  wire       sda_m   = sel ? sda3       : sda1;
  wire       done_m  = sel ? bus3.done  : bus1.done;
  wire [7:0] rdata_m = sel ? bus3.rdata : bus1.rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_rdata;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_newd(input logic v);
    if (sel) bus3.newd = v;
    else     bus1.newd = v;
  endtask

  task automatic set_inputs(input logic [6:0] a, input logic w, input logic [7:0] d, input logic ak);
    bus1.addr = a; bus1.wr = w; bus1.wdata = d; bus1.ack = ak;
    bus3.addr = a; bus3.wr = w; bus3.wdata = d; bus3.ack = ak;
  endtask

  // Timeline model: slot 0 START, 1..8 address, 9 address ACK, then either
  // STOP (NACK) or 10..17 data, 18 data ACK, 19 STOP. Released sda reads 1.
  task automatic run_txn(input string name, input logic [6:0] a, input logic w,
                         input logic [7:0] d, input logic ak, input logic [7:0] rd,
                         input logic mid_newd);
    int pc    = sel ? 3 : 1;
    int ns    = ak ? 20 : 11;
    int span  = ns * 4 * pc;
    int total = span + 2 + 8 * pc;
    int scl_bad = 0;
    int sda_bad = 0;
    int dcount  = 0;
    int dcycle  = -1;
    logic [7:0] ab = {a, ~w};
    logic [7:0] db = w ? d : rd;
    logic [7:0] obs_a = 8'h00;
    logic [7:0] obs_d = 8'h00;
    set_inputs(a, w, d, ak);
    @(posedge clk); #1; set_newd(1'b1);
    @(posedge clk); #1; set_newd(1'b0);
    for (int c = 0; c < total; c++) begin
      int slot;
      int ph;
      logic e_scl;
      logic e_sda;
      if (c > 0) begin @(posedge clk); #1; end
      slot = c / (4 * pc);
      ph   = (c % (4 * pc)) / pc;
      drv_en  = ak && !w && c < span && slot >= 10 && slot <= 17;
      drv_bit = 1'b1;
      if (drv_en) drv_bit = db[17 - slot];
      set_newd(mid_newd && c == span / 2);
      #1;
      if (c >= span) begin
        e_scl = 1'b1;
        e_sda = 1'b1;
      end else begin
        e_scl = (slot == ns - 1) ? (ph != 0) : (ph == 1 || ph == 2);
        if (slot == 0)                    e_sda = (ph < 2);
        else if (slot == ns - 1)          e_sda = (ph >= 2);
        else if (slot <= 8)               e_sda = ab[8 - slot];
        else if (slot >= 10 && slot <= 17) e_sda = db[17 - slot];
        else                              e_sda = 1'b1;
      end
      if (scl_m !== e_scl) scl_bad++;
      if (sda_m !== e_sda) sda_bad++;
      if (c < span && (c % (4 * pc)) == 2 * pc) begin
        if (slot >= 1 && slot <= 8)  obs_a = {obs_a[6:0], sda_m};
        if (slot >= 10 && slot <= 17) obs_d = {obs_d[6:0], sda_m};
      end
      if (done_m === 1'b1) begin
        dcount++;
        if (dcycle < 0) dcycle = c;
      end
    end
    drv_en = 1'b0;
    if (ak && !w) exp_rdata = rd;
    check({name, " scl_wave_errs"}, scl_bad, 0);
    check({name, " sda_wave_errs"}, sda_bad, 0);
    check({name, " addr_byte"}, obs_a, ab);
    if (ak && w) check({name, " wdata_byte"}, obs_d, d);
    check({name, " done_count"}, dcount, 1);
    check({name, " done_cycle"}, dcycle, span + 1);
    check({name, " rdata"}, rdata_m, exp_rdata);
  endtask

  task automatic check_reset_state(input string name);
    check({name, " scl"}, scl_m, 1);
    check({name, " sda"}, sda_m, 1);
    check({name, " done"}, done_m, 0);
    check({name, " rdata"}, rdata_m, 0);
  endtask

  initial begin
    int busy;
    sel = 1'b0; drv_en = 1'b0; drv_bit = 1'b1; rst = 1'b1;
    bus1.newd = 1'b0; bus3.newd = 1'b0;
    set_inputs(7'h00, 1'b0, 8'h00, 1'b0);
    exp_rdata = 8'h00;

    // Reset while idle.
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_idle_pc1");
    sel = 1'b1; #1;
    check_reset_state("rst_idle_pc3");
    sel = 1'b0;
    rst = 1'b0;

    // Directed transactions on the PHASE_CLKS=1 instance.
    run_txn("wr_55_a5", 7'h55, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b1);
    run_txn("rd_55_3c", 7'h55, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0);
    run_txn("addr_nack", 7'h12, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    run_txn("rd_addr_nack", 7'h33, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0);

    for (int i = 0; i < 4; i++) begin
      logic [6:0] ra = 7'($urandom);
      logic       rw = 1'($urandom_range(0, 1));
      logic [7:0] rdw = 8'($urandom);
      logic [7:0] rdr = 8'($urandom);
      logic       rk = ($urandom_range(0, 3) != 0);
      run_txn($sformatf("rand%0d", i), ra, rw, rdw, rk, rdr, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the address byte, with newd high during reset.
    set_inputs(7'h55, 1'b1, 8'hA5, 1'b1);
    @(posedge clk); #1; set_newd(1'b1);
    @(posedge clk); #1; set_newd(1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; set_newd(1'b1);
    repeat (2) @(posedge clk);
    #1;
    exp_rdata = 8'h00;
    check_reset_state("rst_mid_addr");
    rst = 1'b0; set_newd(1'b0);
    busy = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (scl_m !== 1'b1 || sda_m !== 1'b1 || done_m !== 1'b0) busy++;
    end
    check("post_rst_bus_activity", busy, 0);

    // Back-to-back write then read on the PHASE_CLKS=3 instance.
    sel = 1'b1;
    run_txn("pc3_wr", 7'h2A, 1'b1, 8'hC3, 1'b1, 8'h00, 1'b0);
    run_txn("pc3_rd", 7'h71, 1'b0, 8'h00, 1'b1, 8'h96, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
Single-byte I2C master controller with a simplified acknowledge model. One request (newd) performs START, a 7-bit address plus R/W bit, one data byte (write or read), and STOP. It then pulses done. The host side is a simple strobe interface; the bus side drives scl and the bidirectional sda line. The slave acknowledge is supplied on the dedicated ack input rather than sampled from sda.

Parameters:
PHASE_CLKS, 1, system clocks per quarter-bit phase. Each bus bit slot is 4 phases; must be ≥1.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
newd  in  1  start-transaction strobe; sampled only in IDLE
ack  in  1  slave acknowledge, sampled in ACK slots; 1=ACK, 0=NACK
wr  in  1  1=write transaction, 0=read transaction
wdata  in  8  byte to write
addr  in  7  slave address
scl  out  1  I2C clock, push-pull, idle high
sda  inout  1  I2C data; driven by master or released (z)
rdata  out  8  last byte read, MSB first
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high; wins over newd):
  - State goes to IDLE; scl=1; sda released (z); done=0; rdata=8'h00; bit and phase counters cleared.
  - Reset mid-transaction aborts immediately, with no STOP generated.
- IDLE: scl=1, sda released.
  - On newd=1 at a clock edge: latch addr, wr, wdata into internal registers and go to START.
  - Inputs are not re-sampled until the next IDLE; newd while busy is ignored.
- Bit slot = 4 phases (P0..P3), each PHASE_CLKS clocks:
  - P0: scl=0, sda updated.
  - P1: scl=1.
  - P2: scl=1, sample point.
  - P3: scl=0.
- States and sequence:
  - START: sda=1 in P0/P1; sda=0 in P2/P3 while scl=1 in P1/P2.
  - ADDR: 8 bits MSB first = {addr[6:0], ~wr}; master drives sda.
  - ADDR_ACK: sda released; ack sampled in P2.
  - WDATA (wr=1): wdata MSB first, master drives sda.
  - RDATA (wr=0): sda released; shift in sda at P2 of each bit, MSB first. Copy the shift register to rdata at the end of bit 0.
  - DATA_ACK:
    - Write: sda released, ack sampled in P2.
    - Read: master drives sda=1 (NACK, last byte).
  - STOP: sda=0 in P0/P1; sda=1 (released) from P2; scl=1 from P1.
  - DONE: done=1 for exactly one clock, then IDLE.
- NACK (ack=0 at sample) in ADDR_ACK or write DATA_ACK: go directly to STOP, then DONE. rdata is unchanged. No separate error output.
- Latency with no NACK: 20 slots × 4 × PHASE_CLKS clocks from the newd edge to the final STOP phase, then done in the following cycle. With PHASE_CLKS=1, done asserts 81 clocks after newd is sampled.
- Drive rules:
  - Master drives sda only in START, ADDR, WDATA, read DATA_ACK, and STOP.
  - sda is z elsewhere.
  - Driven values are 0/1 push-pull.
- rdata holds its value across write transactions.

Decomposition:
- Shared package: state enum (IDLE, START, ADDR, ADDR_ACK, WDATA, RDATA, DATA_ACK, STOP, DONE) and phase encoding constants P0..P3.
- One natural sub-module, i2c_phase_gen: a divider producing a phase index plus a phase-end strobe.
- The FSM, shift registers and sda tri-state stay in i2c_master.

Test Plan:
- Reset for 2 clocks mid-idle and mid-ADDR → scl=1, sda=z, done=0, rdata=00 on the next edge; no further bus activity.
- Write: addr=7'h55, wdata=8'hA5, wr=1, ack held 1, one-clock newd pulse.
  - → START, sda bits 1,0,1,0,1,0,1,0 for 0xAA, then 1,0,1,0,0,1,0,1 for 0xA5, then STOP.
  - → done pulses exactly once, 81 clocks after newd.
- Read: addr=7'h55, wr=0, ack=1; bench drives sda=8'h3C during the RDATA P2 samples.
  - → address byte 0xAB, master NACK (sda=1) in DATA_ACK, rdata=8'h3C at done.
- Address NACK: ack=0 during ADDR_ACK → no data byte, STOP immediately, done pulse; rdata unchanged.
- newd pulsed again mid-transaction and with rst high simultaneously → ignored and no transaction respectively.
- Back-to-back: write then read with PHASE_CLKS=3 → scl high/low each 6 clocks per half-slot; both transactions complete, each with one done pulse.
